// File: rtl/fu_arbiter.sv
// fu_arbiter: shares one combinational FunctionUnit between two requesters,
// round-robin or fixed priority, with one operation in flight at a time.
module fu_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          RR_EN      = 1'b1,
  parameter logic [6:0]  NOP_OPCODE = 7'h13
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [6:0]       req0_opcode,
  input  logic [3:0]       req0_fs,
  input  logic [4:0]       req0_sh,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [6:0]       req1_opcode,
  input  logic [3:0]       req1_fs,
  input  logic [4:0]       req1_sh,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_fout,
  output logic [3:0]       rsp_flags,

  output logic [6:0]       fu_opcode,
  output logic [3:0]       fu_fs,
  output logic [4:0]       fu_sh,
  output logic [WIDTH-1:0] fu_a,
  output logic [WIDTH-1:0] fu_b,
  input  logic [WIDTH-1:0] fu_fout,
  input  logic             fu_overflow,
  input  logic             fu_carryout,
  input  logic             fu_negative,
  input  logic             fu_zero,

  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             r_ptr;
  logic             r_owner;
  logic [6:0]       r_fuOpcode;
  logic [3:0]       r_fuFs;
  logic [4:0]       r_fuSh;
  logic [WIDTH-1:0] r_fuA;
  logic [WIDTH-1:0] r_fuB;
  logic [WIDTH-1:0] r_rspFout;
  logic [3:0]       r_rspFlags;

  logic w_win0;
  logic w_win1;
  logic w_grant0;
  logic w_grant1;
  logic w_rspDone;

  // Port 0 wins unless port 1 is alone or the round-robin pointer names it.
  assign w_win0 = req0_valid && (!req1_valid || !RR_EN || !r_ptr);
  assign w_win1 = req1_valid && !w_win0;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    w_rspDone   = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant0 = w_win0;
        w_grant1 = w_win1;
        if (w_win0 || w_win1) w_nextState = EXEC;
      end
      EXEC: w_nextState = RESP;
      RESP: begin
        w_rspDone = r_owner ? rsp1_ready : rsp0_ready;
        if (w_rspDone) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The FunctionUnit inputs double as the operand registers; opcode and
  // operands fall back to NOP/zero once EXEC is over to keep the unit quiet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr      <= 1'b0;
      r_owner    <= 1'b0;
      r_fuOpcode <= NOP_OPCODE;
      r_fuFs     <= '0;
      r_fuSh     <= '0;
      r_fuA      <= '0;
      r_fuB      <= '0;
      r_rspFout  <= '0;
      r_rspFlags <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_owner    <= w_grant1;
            r_fuOpcode <= w_grant1 ? req1_opcode : req0_opcode;
            r_fuFs     <= w_grant1 ? req1_fs     : req0_fs;
            r_fuSh     <= w_grant1 ? req1_sh     : req0_sh;
            r_fuA      <= w_grant1 ? req1_a      : req0_a;
            r_fuB      <= w_grant1 ? req1_b      : req0_b;
            if (req0_valid && req1_valid) r_ptr <= w_grant0;
          end
        end
        EXEC: begin
          r_rspFout  <= fu_fout;
          r_rspFlags <= {fu_overflow, fu_carryout, fu_negative, fu_zero};
          r_fuOpcode <= NOP_OPCODE;
          r_fuA      <= '0;
          r_fuB      <= '0;
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign rsp0_valid = (r_state == RESP) && !r_owner;
  assign rsp1_valid = (r_state == RESP) && r_owner;
  assign rsp_fout   = r_rspFout;
  assign rsp_flags  = r_rspFlags;
  assign fu_opcode  = r_fuOpcode;
  assign fu_fs      = r_fuFs;
  assign fu_sh      = r_fuSh;
  assign fu_a       = r_fuA;
  assign fu_b       = r_fuB;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_fu_arbiter.sv
// tb_fu_arbiter: table-driven and scoreboard-checked bench for fu_arbiter,
// with a small FunctionUnit stand-in and a second fixed-priority instance.
module tb_fu_arbiter;

  localparam int         W      = 32;
  localparam logic [6:0] NOP    = 7'h13;
  localparam logic [6:0] OP_ALU = 7'h33;

  typedef struct {
    logic        port;
    logic [31:0] fout;
    logic [3:0]  flags;
  } exp_t;

  typedef struct {
    logic        port;
    logic [6:0]  opcode;
    logic [3:0]  fs;
    logic [4:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expFout;
    logic [3:0]  expFlags;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [6:0] req0_opcode, req1_opcode;
  logic [3:0] req0_fs, req1_fs;
  logic [4:0] req0_sh, req1_sh;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;

  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [W-1:0] rsp_fout, fu_a, fu_b, fu_fout;
  logic [3:0] rsp_flags, fu_fs;
  logic [6:0] fu_opcode;
  logic [4:0] fu_sh;
  logic fu_overflow, fu_carryout, fu_negative, fu_zero;

  logic fxReq0Ready, fxReq1Ready, fxRsp0Valid, fxRsp1Valid, fxBusy;
  logic [W-1:0] fxRspFout, fxFuA, fxFuB, fxFuFout;
  logic [3:0] fxRspFlags, fxFuFs;
  logic [6:0] fxFuOpcode;
  logic [4:0] fxFuSh;
  logic fxOv, fxCo, fxNeg, fxZero;

  int errors = 0;
  int checks = 0;
  exp_t sbQueue[$];
  exp_t sbHead;
  vec_t vecs[7];

  always #5 clk = ~clk;

  fu_arbiter #(.WIDTH(W), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_fs(req0_fs), .req0_sh(req0_sh), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_fs(req1_fs), .req1_sh(req1_sh), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_fout(rsp_fout), .rsp_flags(rsp_flags),
    .fu_opcode(fu_opcode), .fu_fs(fu_fs), .fu_sh(fu_sh), .fu_a(fu_a), .fu_b(fu_b),
    .fu_fout(fu_fout), .fu_overflow(fu_overflow), .fu_carryout(fu_carryout),
    .fu_negative(fu_negative), .fu_zero(fu_zero), .busy(busy)
  );

  fu_arbiter #(.WIDTH(W), .RR_EN(1'b0)) dutFixed (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fxReq0Ready), .req0_opcode(req0_opcode),
    .req0_fs(req0_fs), .req0_sh(req0_sh), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(fxReq1Ready), .req1_opcode(req1_opcode),
    .req1_fs(req1_fs), .req1_sh(req1_sh), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(fxRsp0Valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(fxRsp1Valid), .rsp1_ready(rsp1_ready),
    .rsp_fout(fxRspFout), .rsp_flags(fxRspFlags),
    .fu_opcode(fxFuOpcode), .fu_fs(fxFuFs), .fu_sh(fxFuSh), .fu_a(fxFuA), .fu_b(fxFuB),
    .fu_fout(fxFuFout), .fu_overflow(fxOv), .fu_carryout(fxCo),
    .fu_negative(fxNeg), .fu_zero(fxZero), .busy(fxBusy)
  );

  // FunctionUnit stand-in: fs selects add/sub/and/or; flags {ov, carry, neg, zero}.
  function automatic logic [35:0] fuModel(input logic [3:0] fs, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] sum;
    logic [31:0] r;
    logic c, ov;
    sum = '0; r = '0; c = 1'b0; ov = 1'b0;
    case (fs)
      4'd0: begin
        sum = {1'b0, a} + {1'b0, b};
        r = sum[31:0]; c = sum[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd1: begin
        sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = sum[31:0]; c = sum[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      default: r = '0;
    endcase
    return {ov, c, r[31], (r == 32'd0), r};
  endfunction

  always_comb {fu_overflow, fu_carryout, fu_negative, fu_zero, fu_fout} = fuModel(fu_fs, fu_a, fu_b);
  always_comb {fxOv, fxCo, fxNeg, fxZero, fxFuFout} = fuModel(fxFuFs, fxFuA, fxFuB);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic port, input logic valid, input logic [6:0] opcode,
                               input logic [3:0] fs, input logic [4:0] sh,
                               input logic [31:0] a, input logic [31:0] b);
    if (port) begin
      req1_valid = valid; req1_opcode = opcode; req1_fs = fs; req1_sh = sh; req1_a = a; req1_b = b;
    end else begin
      req0_valid = valid; req0_opcode = opcode; req0_fs = fs; req0_sh = sh; req0_a = a; req0_b = b;
    end
  endtask

  function automatic logic readyOf(input logic port);
    return port ? req1_ready : req0_ready;
  endfunction

  function automatic logic rspValidOf(input logic port);
    return port ? rsp1_valid : rsp0_valid;
  endfunction

  // One complete transaction with rsp ready high; entered and left at negedge+1 in IDLE.
  task automatic runOp(input vec_t v);
    int n;
    applyStimulus(v.port, 1'b1, v.opcode, v.fs, v.sh, v.a, v.b);
    #1;
    n = 0;
    while (!readyOf(v.port) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checkOutput("grant", readyOf(v.port), 1);
    if (!readyOf(v.port)) begin
      applyStimulus(v.port, 1'b0, v.opcode, v.fs, v.sh, v.a, v.b);
      return;
    end
    sbQueue.push_back('{v.port, v.expFout, v.expFlags});
    @(negedge clk);
    checkOutput("exec fu_a", fu_a, v.a);
    checkOutput("exec fu_b", fu_b, v.b);
    checkOutput("exec fu_opcode", fu_opcode, v.opcode);
    checkOutput("exec fu_fs", fu_fs, v.fs);
    checkOutput("exec fu_sh", fu_sh, v.sh);
    checkOutput("exec ready low", readyOf(v.port), 0);
    #1 applyStimulus(v.port, 1'b0, v.opcode, v.fs, v.sh, v.a, v.b);
    @(negedge clk);
    checkOutput("resp valid", rspValidOf(v.port), 1);
    checkOutput("resp other valid", rspValidOf(!v.port), 0);
    checkOutput("resp fu_opcode nop", fu_opcode, NOP);
    checkOutput("resp fu_a zero", fu_a, 0);
    @(negedge clk);
    checkOutput("idle busy", busy, 0);
    #1;
  endtask

  // Scoreboard monitor samples late in the low phase, after inputs have settled.
  always begin
    @(negedge clk);
    #3;
    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
      checkOutput("rsp expected", sbQueue.size() > 0, 1);
      if (sbQueue.size() > 0) begin
        sbHead = sbQueue.pop_front();
        checkOutput("rsp port", rsp1_valid, sbHead.port);
        checkOutput("rsp fout", rsp_fout, sbHead.fout);
        checkOutput("rsp flags", rsp_flags, sbHead.flags);
      end
    end
    if (rsp0_valid || rsp1_valid) checkOutput("rsp onehot", rsp0_valid && rsp1_valid, 0);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic e0, e1;
    int n;
    vecs[0] = '{1'b0, OP_ALU, 4'd0, 5'd0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 4'b0000};
    vecs[1] = '{1'b1, OP_ALU, 4'd1, 5'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0010};
    vecs[2] = '{1'b0, OP_ALU, 4'd0, 5'd2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0101};
    vecs[3] = '{1'b1, OP_ALU, 4'd0, 5'd3, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1010};
    vecs[4] = '{1'b0, OP_ALU, 4'd1, 5'd4, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0101};
    vecs[5] = '{1'b1, 7'h13,  4'd2, 5'd31, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000};
    vecs[6] = '{1'b0, 7'h0B,  4'd3, 5'd17, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 4'b0010};

    rst_n = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, NOP, 4'd0, 5'd0, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, NOP, 4'd0, 5'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset req0_ready", req0_ready, 0);
    checkOutput("reset req1_ready", req1_ready, 0);
    checkOutput("reset rsp0_valid", rsp0_valid, 0);
    checkOutput("reset rsp1_valid", rsp1_valid, 0);
    checkOutput("reset rsp_fout", rsp_fout, 0);
    checkOutput("reset rsp_flags", rsp_flags, 0);
    checkOutput("reset fu_opcode", fu_opcode, NOP);
    checkOutput("reset fu_a", fu_a, 0);
    checkOutput("reset fu_b", fu_b, 0);
    checkOutput("reset fu_fs", fu_fs, 0);
    checkOutput("reset fu_sh", fu_sh, 0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) runOp(vecs[i]);

    // Both ports request SUB continuously: rr alternates, fixed always port 0.
    applyStimulus(1'b0, 1'b1, OP_ALU, 4'd1, 5'd0, 32'd10, 32'd4);
    applyStimulus(1'b1, 1'b1, OP_ALU, 4'd1, 5'd0, 32'd0, 32'd1);
    for (int c = 0; c < 18; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      e0 = (c % 3 == 0) && ((c / 3) % 2 == 0);
      e1 = (c % 3 == 0) && ((c / 3) % 2 == 1);
      checkOutput($sformatf("rr req0_ready c%0d", c), req0_ready, e0);
      checkOutput($sformatf("rr req1_ready c%0d", c), req1_ready, e1);
      checkOutput($sformatf("fixed req0_ready c%0d", c), fxReq0Ready, (c % 3 == 0));
      checkOutput($sformatf("fixed req1_ready c%0d", c), fxReq1Ready, 0);
      if (e0) sbQueue.push_back('{1'b0, 32'd6, 4'b0100});
      if (e1) sbQueue.push_back('{1'b1, 32'hFFFF_FFFF, 4'b0010});
    end
    @(negedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, OP_ALU, 4'd1, 5'd0, 32'd10, 32'd4);
    applyStimulus(1'b1, 1'b0, OP_ALU, 4'd1, 5'd0, 32'd0, 32'd1);
    @(negedge clk);
    checkOutput("rr drained busy", busy, 0);

    // Port 1 response stalled for 5 cycles while port 0 waits.
    #1 rsp1_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, OP_ALU, 4'd0, 5'd0, 32'd2, 32'd3);
    #1 checkOutput("stall grant1", req1_ready, 1);
    sbQueue.push_back('{1'b1, 32'd5, 4'b0000});
    @(negedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, OP_ALU, 4'd0, 5'd0, 32'd2, 32'd3);
    applyStimulus(1'b0, 1'b1, OP_ALU, 4'd0, 5'd0, 32'd100, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("stall rsp1_valid k%0d", k), rsp1_valid, 1);
      checkOutput($sformatf("stall rsp_fout k%0d", k), rsp_fout, 32'd5);
      checkOutput($sformatf("stall rsp_flags k%0d", k), rsp_flags, 4'b0000);
      checkOutput($sformatf("stall req0_ready k%0d", k), req0_ready, 0);
      checkOutput($sformatf("stall rsp0_valid k%0d", k), rsp0_valid, 0);
    end
    #1 rsp1_ready = 1'b1;
    @(negedge clk);
    #1 checkOutput("after stall grant0", req0_ready, 1);
    sbQueue.push_back('{1'b0, 32'd101, 4'b0000});
    @(negedge clk);
    #1 applyStimulus(1'b0, 1'b0, OP_ALU, 4'd0, 5'd0, 32'd100, 32'd1);
    @(negedge clk);
    checkOutput("after stall rsp0_valid", rsp0_valid, 1);
    @(negedge clk);

    // Reset while port 0's op is in EXEC: the op must vanish.
    #1 applyStimulus(1'b0, 1'b1, OP_ALU, 4'd0, 5'd0, 32'd7, 32'd9);
    #1 checkOutput("rst grant0", req0_ready, 1);
    @(negedge clk);
    checkOutput("rst exec busy", busy, 1);
    #1 rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, OP_ALU, 4'd0, 5'd0, 32'd7, 32'd9);
    @(negedge clk);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst req0_ready", req0_ready, 0);
    checkOutput("rst req1_ready", req1_ready, 0);
    checkOutput("rst rsp0_valid", rsp0_valid, 0);
    checkOutput("rst rsp1_valid", rsp1_valid, 0);
    checkOutput("rst fu_opcode", fu_opcode, NOP);
    checkOutput("rst fu_a", fu_a, 0);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rst no rsp0 k%0d", k), rsp0_valid, 0);
    end

    // Port 1 gives up before being granted; pointer must still name port 0.
    #1 applyStimulus(1'b0, 1'b1, OP_ALU, 4'd0, 5'd0, 32'd20, 32'd22);
    #1 checkOutput("drop grant0", req0_ready, 1);
    sbQueue.push_back('{1'b0, 32'd42, 4'b0000});
    @(negedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, OP_ALU, 4'd0, 5'd0, 32'd20, 32'd22);
    applyStimulus(1'b1, 1'b1, OP_ALU, 4'd0, 5'd0, 32'd1, 32'd1);
    #1 checkOutput("drop exec req1_ready", req1_ready, 0);
    @(negedge clk);
    checkOutput("drop resp req1_ready", req1_ready, 0);
    #1 applyStimulus(1'b1, 1'b0, OP_ALU, 4'd0, 5'd0, 32'd1, 32'd1);
    @(negedge clk);
    checkOutput("drop idle busy", busy, 0);
    checkOutput("drop idle req1_ready", req1_ready, 0);
    #1;
    applyStimulus(1'b0, 1'b1, OP_ALU, 4'd0, 5'd0, 32'd3, 32'd4);
    applyStimulus(1'b1, 1'b1, OP_ALU, 4'd0, 5'd0, 32'd9, 32'd9);
    #1;
    checkOutput("ptr kept req0_ready", req0_ready, 1);
    checkOutput("ptr kept req1_ready", req1_ready, 0);
    if (req0_ready) sbQueue.push_back('{1'b0, 32'd7, 4'b0000});
    @(negedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, OP_ALU, 4'd0, 5'd0, 32'd3, 32'd4);
    applyStimulus(1'b1, 1'b0, OP_ALU, 4'd0, 5'd0, 32'd9, 32'd9);
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk); n++;
    end
    repeat (2) @(negedge clk);
    checkOutput("scoreboard drained", sbQueue.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
